rr_shared_adder_arbiter: RTL and testbench



---
 rtl/rr_shared_adder_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_shared_adder_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_shared_adder_arbiter.sv
// Shared adder with round-robin arbitration across n_req requesters.
// Granted operand pairs are summed, tagged with the requester index and queued
// in a 2-entry output FIFO. The FIFO head is registered and drives res_data/res_id.
// req_ready depends only on req_valid, rr_ptr and count, never on res_ready.
module rr_shared_adder_arbiter #(
    parameter int unsigned width = 8,
    parameter int unsigned n_req = 4,
    localparam int unsigned id_w = $clog2(n_req)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [n_req-1:0]       req_valid,
    output logic [n_req-1:0]       req_ready,
    input  logic [n_req*width-1:0] req_a,
    input  logic [n_req*width-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [width-1:0]       res_data,
    output logic [id_w-1:0]        res_id
);

    logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [width-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [id_w-1:0]  head_id_q, head_id_d, tail_id_q, tail_id_d;

    logic             hi_found, lo_found;
    logic [id_w-1:0]  hi_idx, lo_idx, grant;
    logic             push, pop;
    logic [width-1:0] sum;

    // Round-robin pick: lowest valid index >= rr_ptr, else lowest valid index overall
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = n_req - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = id_w'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = id_w'(i);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

    // One-hot ready to the granted requester while the FIFO has room and reset is released
    always_comb begin
        req_ready = '0;
        if (lo_found && (count_q != 2'd2) && rst_n) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign push      = |req_ready;
    assign res_valid = (count_q != 2'd0);
    assign pop       = res_valid && res_ready;
    assign sum       = req_a[grant*width +: width] + req_b[grant*width +: width];
    assign res_data  = head_data_q;
    assign res_id    = head_id_q;

    // Next-state for pointer and FIFO; pop shifts tail into head, push fills the first free slot
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_id_d   = head_id_q;
        tail_data_d = tail_data_q;
        tail_id_d   = tail_id_q;
        if (push) begin
            rr_ptr_d = (grant == id_w'(n_req - 1)) ? '0 : grant + 1'b1;
        end
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = sum;
                    head_id_d   = grant;
                end else begin
                    tail_data_d = sum;
                    tail_id_d   = grant;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_id_d   = tail_id_q;
                tail_data_d = '0;
                tail_id_d   = '0;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at count 1: old head leaves, new entry takes its place
                head_data_d = sum;
                head_id_d   = grant;
            end
            default: ;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_id_q   <= '0;
            tail_data_q <= '0;
            tail_id_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_id_q   <= head_id_d;
            tail_data_q <= tail_data_d;
            tail_id_q   <= tail_id_d;
        end
    end

endmodule

// File: tb/tb_rr_shared_adder_arbiter.sv
// Bench for rr_shared_adder_arbiter: queue-based reference model checked every
// negative edge, plus directed scenarios with hand-computed expectations.
module tb_rr_shared_adder_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;

    int n_checks = 0;
    int n_fail   = 0;

    rr_shared_adder_arbiter #(.width(W), .n_req(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_rr;
    int          mq_id[$];
    int          mq_data[$];
    bit          p_ok;
    logic [N-1:0] p_valid, p_acc;
    logic [N*W-1:0] p_a, p_b;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        m_rr = 0;
        p_ok = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq_id.delete();
                mq_data.delete();
                m_rr = 0;
                p_ok = 1'b0;
            end else begin
                int g;
                int av, bv;
                bit acc, popd;
                if (p_ok) begin
                    for (int i = 0; i < N; i++) begin
                        if (p_valid[i] && !p_acc[i] && (!req_valid[i] ||
                            req_a[i*W +: W] != p_a[i*W +: W] || req_b[i*W +: W] != p_b[i*W +: W]))
                            $error("requester %0d dropped or changed before transfer", i);
                    end
                end
                g    = model_grant();
                acc  = (g >= 0) && (mq_id.size() < 2);
                popd = (mq_id.size() > 0) && res_ready;
                p_acc = '0;
                if (popd) begin
                    void'(mq_id.pop_front());
                    void'(mq_data.pop_front());
                end
                if (acc) begin
                    av = req_a[g*W +: W];
                    bv = req_b[g*W +: W];
                    mq_id.push_back(g);
                    mq_data.push_back((av + bv) % 256);
                    m_rr = (g + 1) % N;
                    p_acc[g] = 1'b1;
                end
                p_valid = req_valid;
                p_a     = req_a;
                p_b     = req_b;
                p_ok    = 1'b1;
            end
        end
    end

    // Compare DUT against the model every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst req_ready", req_ready, 0);
                check("rst res_valid", res_valid, 0);
                check("rst res_data", res_data, 0);
                check("rst res_id", res_id, 0);
            end else begin
                int g;
                logic [N-1:0] er;
                g  = model_grant();
                er = '0;
                if (g >= 0 && mq_id.size() < 2) er[g] = 1'b1;
                check("model req_ready", req_ready, er);
                check("model res_valid", res_valid, int'(mq_id.size() != 0));
                if (mq_id.size() != 0) begin
                    check("model res_data", res_data, mq_data[0]);
                    check("model res_id", res_id, mq_id[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b0;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9abc_def0;

        // Reset with everyone valid: nothing ready, nothing out
        repeat (3) step();
        check("reset req_ready", req_ready, 0);
        check("reset res_valid", res_valid, 0);
        req_valid = 4'b0001;
        req_a = '0;
        req_b = '0;
        set_op(0, 3, 4);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("first res_valid", res_valid, 1);
        check("first res_data 3+4", res_data, 7);
        check("first res_id", res_id, 0);
        req_valid = '0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Carry discarded: 200+100 = 300 -> 44
        set_op(2, 200, 100);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        check("wrap res_data", res_data, 44);
        check("wrap res_id", res_id, 2);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Round robin from rr_ptr=0, one result per cycle
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 10 * i + 1, 5);
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("rr res_valid", res_valid, 1);
            check("rr res_id", res_id, k % N);
            check("rr res_data", res_data, 10 * (k % N) + 6);
            if (k >= 8) req_valid[k % N] = 1'b0;
        end
        step();
        check("rr drained", res_valid, 0);

        // Backpressure with requesters 1 and 3
        res_ready = 1'b0;
        set_op(1, 11, 1);
        set_op(3, 33, 3);
        req_valid = 4'b1010;
        step();
        check("bp A id", res_id, 1);
        req_valid = 4'b1000;
        step();
        check("bp full req_ready", req_ready, 0);
        check("bp B id", res_id, 1);
        check("bp B data", res_data, 12);
        set_op(0, 128, 128);
        set_op(1, 50, 60);
        req_valid = 4'b1011;
        step();
        check("bp hold id", res_id, 1);
        check("bp hold data", res_data, 12);
        check("bp hold req_ready", req_ready, 0);
        res_ready = 1'b1;
        step();
        check("bp D id", res_id, 3);
        check("bp D data", res_data, 36);
        step();
        check("bp E id rr0", res_id, 0);
        check("bp E data", res_data, 0);
        req_valid = 4'b1010;
        step();
        check("bp F id", res_id, 1);
        check("bp F data", res_data, 110);
        req_valid = 4'b1000;
        step();
        check("bp G id", res_id, 3);
        req_valid = '0;
        step();
        check("bp drained", res_valid, 0);

        // Push and pop together at count 1, random operands
        res_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            set_op(0, a, b);
            req_valid = 4'b0001;
            step();
            check("pp res_valid", res_valid, 1);
            check("pp res_data", res_data, (a + b) % 256);
            check("pp res_id", res_id, 0);
        end
        req_valid = '0;
        step();
        check("pp drained", res_valid, 0);

        // Asynchronous reset with two buffered results
        res_ready = 1'b0;
        set_op(1, 1, 2);
        set_op(3, 3, 4);
        req_valid = 4'b1010;
        step();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        check("pre-reset res_valid", res_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async res_valid", res_valid, 0);
        check("async res_id", res_id, 0);
        check("async res_data", res_data, 0);
        res_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("no stale result", res_valid, 0);
        for (int i = 0; i < N; i++) set_op(i, i, 100);
        req_valid = '1;
        step();
        check("post-reset rr id", res_id, 0);
        check("post-reset data", res_data, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
